// File: rtl/useq_sequencer_if.sv
// Sequencer bundle: ROM address/data, datapath control word, conditions, IRQ and status.
// The master side is the sequencer; the slave side is the ROM, datapath and interrupt logic.
interface useq_sequencer_if #(
  parameter int CW_W       = 112,
  parameter int IR_W       = 8,
  parameter int STEP_LOG2  = 6,
  parameter int COND_SEL_W = 4
);
  localparam int UADDR_W  = 1 + IR_W + STEP_LOG2;
  localparam int NUM_COND = 2 ** COND_SEL_W;

  logic                stall;
  logic [IR_W-1:0]     ir;
  logic [NUM_COND-1:0] alu_flags;
  logic [NUM_COND-1:0] status_flags;
  logic                irq_req;
  logic                irq_en;
  logic [UADDR_W-1:0]  rom_addr;
  logic [CW_W-1:0]     rom_data;
  logic [CW_W-1:0]     cw;
  logic                cw_valid;
  logic [UADDR_W-1:0]  upc;
  logic                irq_taken;
  logic                stk_ovf;
  logic                stk_unf;
  logic                halted;

  modport master (
    input  stall, ir, alu_flags, status_flags, irq_req, irq_en, rom_data,
    output rom_addr, cw, cw_valid, upc, irq_taken, stk_ovf, stk_unf, halted
  );

  modport slave (
    output stall, ir, alu_flags, status_flags, irq_req, irq_en, rom_data,
    input  rom_addr, cw, cw_valid, upc, irq_taken, stk_ovf, stk_unf, halted
  );
endinterface

// File: rtl/useq_sequencer.sv
// Microcode sequencer: owns upc and drives the synchronous ROM address, with the next address presented combinationally so there is no bubble.
// Call/return stack, IRQ entry on fetch and an escape page; stall holds all state and re-reads the ROM at upc.
module useq_sequencer #(
  parameter int CW_W         = 112,
  parameter int IR_W         = 8,
  parameter int STEP_LOG2    = 6,
  parameter int OFFSET_W     = 7,
  parameter int COND_SEL_W   = 4,
  parameter int TYP_POS      = 0,
  parameter int OFFSET_POS   = 2,
  parameter int COND_INV_POS = 9,
  parameter int COND_SRC_POS = 10,
  parameter int COND_SEL_POS = 11,
  parameter int ESCAPE_POS   = 15,
  parameter int CALL_POS     = 87,
  parameter int RET_POS      = 88,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_ADDR   = 0,
  parameter int FETCH_ADDR   = 0,
  parameter int IRQ_ADDR     = 16
) (
  input logic             clk,
  input logic             rst_n,
  useq_sequencer_if.master bus
);
  localparam int UADDR_W = 1 + IR_W + STEP_LOG2;
  localparam int SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0]    SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]    SP_ONE  = SP_W'(1);
  localparam logic [UADDR_W-1:0] A_ONE   = UADDR_W'(1);
  localparam logic [UADDR_W-1:0] A_RESET = UADDR_W'(RESET_ADDR);
  localparam logic [UADDR_W-1:0] A_FETCH = UADDR_W'(FETCH_ADDR);
  localparam logic [UADDR_W-1:0] A_IRQ   = UADDR_W'(IRQ_ADDR);

  typedef enum logic [1:0] {S_PRIME = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [UADDR_W-1:0]    upc_q, nxt, inc, br_tgt, rom_addr;
  logic [UADDR_W-1:0]    stack [2**SP_W];
  logic [SP_W-1:0]       sp, sp_top;
  logic                  esc_q, ovf_q, unf_q;
  logic [1:0]            typ;
  logic [OFFSET_W-1:0]   offset;
  logic [COND_SEL_W-1:0] cond_sel;
  logic                  cond_inv, cond_src, escape, call, ret, c;
  logic                  do_push, do_pop, set_ovf, set_unf, halt_req, irq_hit, clr_esc, advance;
  logic                  cw_valid, halted, irq_taken;

  assign typ      = bus.rom_data[TYP_POS +: 2];
  assign offset   = bus.rom_data[OFFSET_POS +: OFFSET_W];
  assign cond_inv = bus.rom_data[COND_INV_POS];
  assign cond_src = bus.rom_data[COND_SRC_POS];
  assign cond_sel = bus.rom_data[COND_SEL_POS +: COND_SEL_W];
  assign escape   = bus.rom_data[ESCAPE_POS];
  assign call     = bus.rom_data[CALL_POS];
  assign ret      = bus.rom_data[RET_POS];

  assign c       = (cond_src ? bus.status_flags[cond_sel] : bus.alu_flags[cond_sel]) ^ cond_inv;
  assign inc     = upc_q + A_ONE;
  assign br_tgt  = upc_q + {{(UADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign sp_top  = sp - SP_ONE;
  assign advance = (state == S_RUN) && !bus.stall;

  // Next-address selection; RET outranks typ, so push and pop are exclusive.
  always_comb begin
    nxt     = inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    irq_hit = 1'b0;
    clr_esc = 1'b0;
    if (ret) begin
      if (sp == '0) set_unf = 1'b1;
      else begin
        do_pop = 1'b1;
        nxt    = stack[sp_top];
      end
    end else begin
      case (typ)
        2'b01: if (c) begin
          nxt = br_tgt;
          if (call) begin
            if (sp == SP_FULL) set_ovf = 1'b1;
            else               do_push = 1'b1;
          end
        end
        2'b10: begin
          nxt     = {esc_q, bus.ir, {STEP_LOG2{1'b0}}};
          clr_esc = 1'b1;
        end
        2'b11: if (bus.irq_req && bus.irq_en) begin
          nxt     = A_IRQ;
          irq_hit = 1'b1;
        end else nxt = A_FETCH;
        default: nxt = inc;
      endcase
    end
    halt_req = set_ovf | set_unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_PRIME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PRIME: state_nxt = S_RUN;
      S_RUN:   if (advance && halt_req) state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    rom_addr  = upc_q;
    cw_valid  = 1'b0;
    halted    = 1'b0;
    irq_taken = 1'b0;
    case (state)
      S_RUN: begin
        cw_valid  = !bus.stall;
        irq_taken = advance && irq_hit;
        if (advance && !halt_req) rom_addr = nxt;
      end
      S_HALT:  halted = 1'b1;
      default: rom_addr = upc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q <= A_RESET;
      sp    <= '0;
      esc_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (advance) begin
      if (halt_req) begin
        ovf_q <= ovf_q | set_ovf;
        unf_q <= unf_q | set_unf;
      end else begin
        upc_q <= nxt;
        if (do_push) sp <= sp + SP_ONE;
        if (do_pop)  sp <= sp_top;
        // An escape on a decode word still decodes with the old page.
        if (escape)       esc_q <= 1'b1;
        else if (clr_esc) esc_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && do_push) stack[sp] <= inc;
  end

  assign bus.rom_addr  = rom_addr;
  assign bus.cw        = bus.rom_data;
  assign bus.cw_valid  = cw_valid;
  assign bus.upc       = upc_q;
  assign bus.irq_taken = irq_taken;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
  assign bus.halted    = halted;
endmodule
